// File: rtl/opm_ctl_pkg.sv
// Shared types and constants for the OPM write scheduler: FSM states and FIFO entries.
package opm_ctl_pkg;

  localparam int unsigned OPM_DW   = 8;
  localparam int unsigned BUSY_BIT = 7;

  typedef struct packed {
    logic [OPM_DW-1:0] addr;
    logic [OPM_DW-1:0] data;
  } opm_wr_entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HLD,
    S_D_SET,
    S_D_STB,
    S_D_HLD,
    S_P_STB,
    S_P_CHK
  } opm_wr_state_t;

endpackage

// File: rtl/opm_write_scheduler_if.sv
// Host request handshake plus the OPM chip pin bundle owned by the scheduler.
interface opm_write_scheduler_if;
  import opm_ctl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OPM_DW-1:0] req_addr;
  logic [OPM_DW-1:0] req_data;

  logic              opm_cs_n;
  logic              opm_wr_n;
  logic              opm_rd_n;
  logic              opm_a0;
  logic [OPM_DW-1:0] opm_d;
  logic [OPM_DW-1:0] opm_q;
  logic              opm_q_oe;

  // master: host + chip side; slave: the scheduler
  modport master (
    output req_valid, req_addr, req_data, opm_q, opm_q_oe,
    input  req_ready, opm_cs_n, opm_wr_n, opm_rd_n, opm_a0, opm_d
  );

  modport slave (
    input  req_valid, req_addr, req_data, opm_q, opm_q_oe,
    output req_ready, opm_cs_n, opm_wr_n, opm_rd_n, opm_a0, opm_d
  );

endinterface

// File: rtl/opm_wr_fifo.sv
// Synchronous FIFO of pending register writes, with flush, occupancy and a registered ready.
module opm_wr_fifo
  import opm_ctl_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  opm_wr_entry_t wdata_i,
  input  logic          pop_i,
  output opm_wr_entry_t head_c,
  output logic [LW-1:0] level_o,
  output logic          ready_o
);

  opm_wr_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  logic          do_push;
  logic          do_pop;

  // No bypass: ready is the registered not-full flag, so a full FIFO ignores pushes even while popping
  assign do_push = push_i && ready_q && !flush_i;
  assign do_pop  = pop_i && (level_q != '0) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= (level_d != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/opm_write_scheduler.sv
// Replays buffered CPU register writes onto one OPM core's bus and polls busy after each data write.
module opm_write_scheduler
  import opm_ctl_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned STROBE  = 4,
  parameter  int unsigned TIMEOUT = 4096,
  localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  opm_write_scheduler_if.slave  bus,
  output logic [LW-1:0]         level,
  output logic                  active,
  output logic                  timeout_err
);

  localparam int unsigned SW = $clog2(STROBE + 1);
  localparam int unsigned PW = $clog2(TIMEOUT + 1);

  opm_wr_state_t     state_q, state_d;
  opm_wr_entry_t     entry_q, entry_d;
  opm_wr_entry_t     head_c;
  logic [SW-1:0]     strb_q, strb_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [PW-1:0]     poll_inc;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;
  logic              strb_last;
  logic              pop_c;
  logic [LW-1:0]     fifo_level;
  logic              fifo_ready;

  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;
  logic              a0_q, a0_d;
  logic [OPM_DW-1:0] d_q, d_d;
  logic              active_q, active_d;

  opm_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (flush),
    .push_i  (bus.req_valid),
    .wdata_i ({bus.req_addr, bus.req_data}),
    .pop_i   (pop_c),
    .head_c  (head_c),
    .level_o (fifo_level),
    .ready_o (fifo_ready)
  );

  // Sequencer next state, counters and pin values; pins are decoded from the next state so they register in step
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    strb_d    = '0;
    poll_d    = poll_q;
    busy_d    = busy_q;
    tmo_d     = tmo_q;
    pop_c     = 1'b0;
    strb_last = (strb_q == SW'(STROBE - 1));
    poll_inc  = (poll_q < PW'(TIMEOUT)) ? poll_q + PW'(1) : poll_q;

    case (state_q)
      S_IDLE: begin
        if ((fifo_level != '0) && !flush) begin
          pop_c   = 1'b1;
          entry_d = head_c;
          state_d = S_A_SET;
        end
      end
      S_A_SET: state_d = S_A_STB;
      S_A_STB: begin
        if (strb_last) state_d = S_A_HLD;
        else           strb_d  = strb_q + SW'(1);
      end
      S_A_HLD: state_d = S_D_SET;
      S_D_SET: state_d = S_D_STB;
      S_D_STB: begin
        if (strb_last) begin
          state_d = S_D_HLD;
          poll_d  = '0;
        end else begin
          strb_d  = strb_q + SW'(1);
        end
      end
      S_D_HLD: state_d = S_P_STB;
      S_P_STB: begin
        poll_d = poll_inc;
        if (strb_last) begin
          // A chip that is not driving its bus is assumed busy
          busy_d  = bus.opm_q_oe ? bus.opm_q[BUSY_BIT] : 1'b1;
          state_d = S_P_CHK;
        end else begin
          strb_d  = strb_q + SW'(1);
        end
      end
      S_P_CHK: begin
        poll_d = poll_inc;
        if (!busy_q) begin
          state_d = S_IDLE;
        end else if (poll_q >= PW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_P_STB;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    a0_d     = a0_q;
    d_d      = d_q;
    active_d = (state_d != S_IDLE);
    case (state_d)
      S_A_SET, S_A_HLD: begin
        a0_d = 1'b0;
        d_d  = entry_d.addr;
      end
      S_A_STB: begin
        a0_d   = 1'b0;
        d_d    = entry_d.addr;
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
      end
      S_D_SET, S_D_HLD: begin
        a0_d = 1'b1;
        d_d  = entry_d.data;
      end
      S_D_STB: begin
        a0_d   = 1'b1;
        d_d    = entry_d.data;
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
      end
      S_P_STB: begin
        a0_d   = 1'b1;
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      S_P_CHK: a0_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      entry_q  <= '0;
      strb_q   <= '0;
      poll_q   <= '0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      d_q      <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      strb_q   <= strb_d;
      poll_q   <= poll_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      a0_q     <= a0_d;
      d_q      <= d_d;
      active_q <= active_d;
    end
  end

  assign bus.req_ready = fifo_ready;
  assign bus.opm_cs_n  = cs_n_q;
  assign bus.opm_wr_n  = wr_n_q;
  assign bus.opm_rd_n  = rd_n_q;
  assign bus.opm_a0    = a0_q;
  assign bus.opm_d     = d_q;
  assign level         = fifo_level;
  assign active        = active_q;
  assign timeout_err   = tmo_q;

endmodule
